multichannel_pulse_generator: RTL and testbench

- Parametrised successor to the single-channel fixed pulse generator.
- Provides NCH independent pulse outputs sharing one window timebase, with runtime-programmable delay and width per channel and a programmable window length.
- Runs free-running (periodic) or triggered one-shot. Configuration is double-buffered so that changes apply only at window boundaries.
- Sits between the control/config logic and the output pins of the pulse/timing path.

---
 rtl/mcpg_pkg.sv | 14 +
 rtl/multichannel_pulse_generator_pulse_channel_cmp.sv | 56 +++++
 rtl/multichannel_pulse_generator.sv | 141 ++++++++++++++
 tb/tb_multichannel_pulse_generator.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcpg_pkg.sv
// Shared constants for the multichannel pulse generator: config select codes,
// FSM state encoding and the minimum window length.
package mcpg_pkg;

  localparam logic [1:0] CFG_DELAY  = 2'd0;
  localparam logic [1:0] CFG_WIDTH  = 2'd1;
  localparam logic [1:0] CFG_WINDOW = 2'd2;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam int MIN_WINDOW = 2;

endpackage

// File: rtl/multichannel_pulse_generator_pulse_channel_cmp.sv
// One pulse channel: double-buffered delay/width registers and the registered
// in-window compare that drives one PULSE bit.
module pulse_channel_cmp
  import mcpg_pkg::*;
#(
  parameter int CW        = 16,
  parameter int DEF_DELAY = 32,
  parameter int DEF_WIDTH = 86
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_delay,
  input  logic          we_width,
  input  logic [CW-1:0] wr_data,
  input  logic          load,
  input  logic          run,
  input  logic [CW-1:0] tick,
  output logic          pulse
);

  logic [CW-1:0] dly_sh_q, dly_sh_d;
  logic [CW-1:0] wid_sh_q, wid_sh_d;
  logic [CW-1:0] dly_act_q, dly_act_d;
  logic [CW-1:0] wid_act_q, wid_act_d;
  logic [CW:0]   pulse_end;
  logic          pulse_q, pulse_d;

  always_comb begin
    dly_sh_d  = we_delay ? wr_data : dly_sh_q;
    wid_sh_d  = we_width ? wr_data : wid_sh_q;
    // Active copies take the shadow value held before any write in the same cycle.
    dly_act_d = load ? dly_sh_q : dly_act_q;
    wid_act_d = load ? wid_sh_q : wid_act_q;
    pulse_end = {1'b0, dly_act_q} + {1'b0, wid_act_q};
    pulse_d   = run && (tick >= dly_act_q) && ({1'b0, tick} < pulse_end);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly_sh_q  <= CW'(DEF_DELAY);
      wid_sh_q  <= CW'(DEF_WIDTH);
      dly_act_q <= CW'(DEF_DELAY);
      wid_act_q <= CW'(DEF_WIDTH);
      pulse_q   <= 1'b0;
    end else begin
      dly_sh_q  <= dly_sh_d;
      wid_sh_q  <= wid_sh_d;
      dly_act_q <= dly_act_d;
      wid_act_q <= wid_act_d;
      pulse_q   <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/multichannel_pulse_generator.sv
// Multichannel pulse generator: window timebase, IDLE/RUN FSM and trigger edge
// detect. Define MCPG_TRIG_SYNC_EN to put a two-flop synchroniser on TRIG.
module multichannel_pulse_generator
  import mcpg_pkg::*;
#(
  parameter int NCH        = 4,
  parameter int CW         = 16,
  parameter int DEF_DELAY  = 32,
  parameter int DEF_WIDTH  = 86,
  parameter int DEF_WINDOW = 512
) (
  input  logic                                     CLK,
  input  logic                                     RESET,
  input  logic                                     ENABLE,
  input  logic                                     MODE,
  input  logic                                     TRIG,
  input  logic                                     CFG_WE,
  input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] CFG_CH,
  input  logic [1:0]                               CFG_SEL,
  input  logic [CW-1:0]                            CFG_DATA,
  output logic [NCH-1:0]                           PULSE,
  output logic                                     FRAME,
  output logic                                     BUSY
);

  function automatic logic [CW-1:0] clamp_window(input logic [CW-1:0] w);
    return (w < CW'(MIN_WINDOW)) ? CW'(MIN_WINDOW) : w;
  endfunction

  logic [0:0]     state_q, state_d;
  logic [CW-1:0]  tick_q, tick_d;
  logic [CW-1:0]  win_sh_q, win_sh_d;
  logic [CW-1:0]  win_act_q, win_act_d;
  logic [CW-1:0]  eff_win;
  logic           frame_q, frame_d;
  logic           trig_prev_q;
  logic           trig_in, trig_rise;
  logic           win_start, run;
  logic [NCH-1:0] we_delay, we_width;

`ifdef MCPG_TRIG_SYNC_EN
  logic trig_s1_q, trig_s2_q;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      trig_s1_q <= 1'b0;
      trig_s2_q <= 1'b0;
    end else begin
      trig_s1_q <= TRIG;
      trig_s2_q <= trig_s1_q;
    end
  end

  assign trig_in = trig_s2_q;
`else
  assign trig_in = TRIG;
`endif

  assign trig_rise = trig_in & ~trig_prev_q;
  assign run       = (state_q == ST_RUN);

  always_comb begin
    eff_win   = clamp_window(win_act_q);
    state_d   = state_q;
    tick_d    = tick_q;
    win_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ENABLE && (!MODE || trig_rise)) begin
          state_d   = ST_RUN;
          tick_d    = '0;
          win_start = 1'b1;
        end
      end
      default: begin
        if (tick_q == eff_win - CW'(1)) begin
          tick_d = '0;
          // ENABLE and MODE only matter here, at the window boundary.
          if (ENABLE && !MODE) win_start = 1'b1;
          else                 state_d   = ST_IDLE;
        end else begin
          tick_d = tick_q + CW'(1);
        end
      end
    endcase
    frame_d   = win_start;
    win_act_d = win_start ? win_sh_q : win_act_q;
    win_sh_d  = (CFG_WE && (CFG_SEL == CFG_WINDOW)) ? CFG_DATA : win_sh_q;
  end

  always_comb begin
    we_delay = '0;
    we_width = '0;
    for (int i = 0; i < NCH; i++) begin
      if (CFG_WE && (32'(CFG_CH) == i)) begin
        we_delay[i] = (CFG_SEL == CFG_DELAY);
        we_width[i] = (CFG_SEL == CFG_WIDTH);
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= ST_IDLE;
      tick_q      <= '0;
      frame_q     <= 1'b0;
      trig_prev_q <= 1'b0;
      win_sh_q    <= CW'(DEF_WINDOW);
      win_act_q   <= CW'(DEF_WINDOW);
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      frame_q     <= frame_d;
      trig_prev_q <= trig_in;
      win_sh_q    <= win_sh_d;
      win_act_q   <= win_act_d;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    pulse_channel_cmp #(
      .CW       (CW),
      .DEF_DELAY(DEF_DELAY),
      .DEF_WIDTH(DEF_WIDTH)
    ) u_ch (
      .clk     (CLK),
      .rst_n   (RESET),
      .we_delay(we_delay[g]),
      .we_width(we_width[g]),
      .wr_data (CFG_DATA),
      .load    (win_start),
      .run     (run),
      .tick    (tick_q),
      .pulse   (PULSE[g])
    );
  end

  assign FRAME = frame_q;
  assign BUSY  = run;

endmodule

// File: tb/tb_multichannel_pulse_generator.sv
// Bench for multichannel_pulse_generator: per-cycle scoreboard against a
// reference model, a table of window/pulse measurements, and trigger/reset sequences.
module tb_multichannel_pulse_generator;

  logic        CLK;
  logic        RESET;
  logic        ENABLE;
  logic        MODE;
  logic        TRIG;
  logic        CFG_WE;
  logic [1:0]  CFG_CH;
  logic [1:0]  CFG_SEL;
  logic [15:0] CFG_DATA;
  logic [3:0]  PULSE;
  logic        FRAME;
  logic        BUSY;

`ifdef MCPG_TRIG_SYNC_EN
  localparam int TRIG_LAT = 3;
`else
  localparam int TRIG_LAT = 1;
`endif

  multichannel_pulse_generator dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .ENABLE  (ENABLE),
    .MODE    (MODE),
    .TRIG    (TRIG),
    .CFG_WE  (CFG_WE),
    .CFG_CH  (CFG_CH),
    .CFG_SEL (CFG_SEL),
    .CFG_DATA(CFG_DATA),
    .PULSE   (PULSE),
    .FRAME   (FRAME),
    .BUSY    (BUSY)
  );

  initial CLK = 1'b0;
  always #33 CLK = ~CLK;

  typedef struct packed {
    logic [3:0] pulse;
    logic       frame;
    logic       busy;
  } exp_t;

  typedef struct {
    string name;
    bit    prog;
    int    ch;
    int    dly;
    int    wid;
    int    win;
    int    per;
    int    rise;
    int    len;
  } vec_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  // Reference model state
  bit   m_run;
  int   m_tick;
  int   m_win_sh, m_win_act;
  int   m_dly_sh[4], m_wid_sh[4], m_dly_act[4], m_wid_act[4];
  bit   m_h[3];

  task automatic model_reset();
    m_run = 0;
    m_tick = 0;
    m_win_sh = 512;
    m_win_act = 512;
    for (int i = 0; i < 4; i++) begin
      m_dly_sh[i] = 32; m_wid_sh[i] = 86;
      m_dly_act[i] = 32; m_wid_act[i] = 86;
    end
    for (int i = 0; i < 3; i++) m_h[i] = 0;
  endtask

  task automatic model_step();
    exp_t e;
    bit   rise;
    bit   start;
    int   eff;
`ifdef MCPG_TRIG_SYNC_EN
    rise = m_h[1] && !m_h[2];
`else
    rise = TRIG && !m_h[0];
`endif
    m_h[2] = m_h[1];
    m_h[1] = m_h[0];
    m_h[0] = TRIG;
    for (int i = 0; i < 4; i++)
      e.pulse[i] = m_run && (m_tick >= m_dly_act[i]) && (m_tick < m_dly_act[i] + m_wid_act[i]);
    start = 0;
    if (!m_run) begin
      if (ENABLE && (!MODE || rise)) begin
        m_run = 1; m_tick = 0; start = 1;
      end
    end else begin
      eff = (m_win_act < 2) ? 2 : m_win_act;
      if (m_tick == eff - 1) begin
        m_tick = 0;
        if (ENABLE && !MODE) start = 1;
        else                 m_run = 0;
      end else begin
        m_tick++;
      end
    end
    if (start) begin
      m_win_act = m_win_sh;
      for (int i = 0; i < 4; i++) begin
        m_dly_act[i] = m_dly_sh[i];
        m_wid_act[i] = m_wid_sh[i];
      end
    end
    if (CFG_WE) begin
      case (CFG_SEL)
        2'd0:    m_dly_sh[CFG_CH] = int'(CFG_DATA);
        2'd1:    m_wid_sh[CFG_CH] = int'(CFG_DATA);
        2'd2:    m_win_sh = int'(CFG_DATA);
        default: ;
      endcase
    end
    e.frame = start;
    e.busy  = m_run;
    sb_q.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cycle();
    exp_t e;
    model_step();
    @(posedge CLK);
    #1;
    cyc++;
    n_checks++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL sb cycle %0d: scoreboard empty", cyc);
    end else begin
      e = sb_q.pop_front();
      if ({PULSE, FRAME, BUSY} !== e) begin
        n_fail++;
        $display("FAIL sb cycle %0d: got pulse=%b frame=%b busy=%b expected pulse=%b frame=%b busy=%b",
                 cyc, PULSE, FRAME, BUSY, e.pulse, e.frame, e.busy);
      end
    end
  endtask

  task automatic do_reset(input string nm);
    RESET = 1'b0;
    ENABLE = 0; MODE = 0; TRIG = 0; CFG_WE = 0;
    CFG_CH = '0; CFG_SEL = '0; CFG_DATA = '0;
    #5;
    chk({nm, "_pulse"}, 32'(PULSE), 0);
    chk({nm, "_frame"}, 32'(FRAME), 0);
    chk({nm, "_busy"},  32'(BUSY),  0);
    sb_q.delete();
    model_reset();
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b1;
  endtask

  task automatic cfg_write(input logic [1:0] sel, input int ch, input int data);
    CFG_WE   = 1'b1;
    CFG_SEL  = sel;
    CFG_CH   = 2'(ch);
    CFG_DATA = 16'(data);
    cycle();
    CFG_WE   = 1'b0;
  endtask

  task automatic wait_frame(input string nm);
    int k;
    k = 0;
    do begin
      cycle();
      k++;
    end while (!FRAME && k < 1100);
    chk({nm, "_frame_seen"}, 32'(FRAME), 1);
  endtask

  task automatic measure(input int ch, input int per, output int rise, output int len, output int frame_at);
    rise = -1; len = 0; frame_at = 0;
    for (int k = 1; k <= per; k++) begin
      cycle();
      if (PULSE[ch] === 1'b1) begin
        if (rise < 0) rise = k;
        len++;
      end
      if (FRAME === 1'b1 && frame_at == 0) frame_at = k;
    end
  endtask

  vec_t vt[9];

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rise, len, fat, lat, nfr, nb, n;

    //            name        prog ch dly wid win per rise len
    vt[0] = '{"defaults",   0, 0, 32, 86, 512, 512, 33, 86};
    vt[1] = '{"ch2_d10_w5", 1, 2, 10,  5, 512, 512, 11,  5};
    vt[2] = '{"trunc_w8",   1, 0,  6, 10,   8,   8,  7,  2};
    vt[3] = '{"width0",     1, 1,  3,  0,   8,   8, -1,  0};
    vt[4] = '{"dly_ge_win", 1, 3,  9,  4,   8,   8, -1,  0};
    vt[5] = '{"continuous", 1, 0,  0, 20,   8,   8,  1,  8};
    vt[6] = '{"win1_clamp", 1, 1,  1,  5,   1,   2,  2,  1};
    vt[7] = '{"win0_clamp", 1, 2,  0,  1,   0,   2,  1,  1};
    vt[8] = '{"trunc_ch3",  1, 3,  4, 10,   8,   8,  5,  4};

    RESET = 1'b1;
    ENABLE = 0; MODE = 0; TRIG = 0; CFG_WE = 0;
    CFG_CH = '0; CFG_SEL = '0; CFG_DATA = '0;
    #2;
    do_reset("rst_init");

    // Free-running table cases
    ENABLE = 1'b1;
    MODE   = 1'b0;
    for (int v = 0; v < 9; v++) begin
      if (vt[v].prog) begin
        cfg_write(2'd0, vt[v].ch, vt[v].dly);
        cfg_write(2'd1, vt[v].ch, vt[v].wid);
        cfg_write(2'd2, 0, vt[v].win);
        cfg_write(2'd3, vt[v].ch, 7);
      end
      wait_frame(vt[v].name);
      measure(vt[v].ch, vt[v].per, rise, len, fat);
      chk({vt[v].name, "_rise"},   32'(rise), 32'(vt[v].rise));
      chk({vt[v].name, "_len"},    32'(len),  32'(vt[v].len));
      chk({vt[v].name, "_period"}, 32'(fat),  32'(vt[v].per));
    end

    // One-shot: single TRIG pulse, second TRIG while busy is ignored
    MODE = 1'b1;
    cfg_write(2'd2, 0, 20);
    n = 0;
    do begin
      cycle();
      n++;
    end while (BUSY && n < 100);
    chk("oneshot_idle", 32'(BUSY), 0);
    TRIG = 1'b1;
    lat = 0; nfr = 0; nb = 0;
    for (int k = 1; k <= 60; k++) begin
      cycle();
      if (FRAME === 1'b1) begin
        nfr++;
        if (lat == 0) lat = k;
      end
      if (BUSY === 1'b1) nb++;
      if (k == 1) TRIG = 1'b0;
      if (k == 6) TRIG = 1'b1;
      if (k == 7) TRIG = 1'b0;
    end
    chk("oneshot_latency", 32'(lat), 32'(TRIG_LAT));
    chk("oneshot_frames",  32'(nfr), 1);
    chk("oneshot_busy",    32'(nb),  20);

    // TRIG held high from IDLE: one window only
    TRIG = 1'b1;
    nfr = 0; nb = 0;
    for (int k = 1; k <= 50; k++) begin
      cycle();
      if (FRAME === 1'b1) nfr++;
      if (BUSY === 1'b1) nb++;
      if (k == 30) TRIG = 1'b0;
    end
    chk("held_trig_frames", 32'(nfr), 1);
    chk("held_trig_busy",   32'(nb),  20);

    // ENABLE dropped at tick 100 of a 512 window
    do_reset("rst_en");
    ENABLE = 1'b1;
    MODE   = 1'b0;
    wait_frame("en_drop");
    repeat (100) cycle();
    ENABLE = 1'b0;
    n = 0;
    do begin
      cycle();
      n++;
    end while (BUSY && n < 600);
    chk("en_drop_busy_tail", 32'(n), 412);
    repeat (2) cycle();
    chk("en_drop_pulse", 32'(PULSE), 0);

    // Reset in the middle of the default pulse
    ENABLE = 1'b1;
    wait_frame("mid_pulse");
    repeat (40) cycle();
    chk("mid_pulse_high", 32'(PULSE), 32'hF);
    #20;
    do_reset("rst_mid");
    ENABLE = 1'b1;
    MODE   = 1'b0;
    wait_frame("post_reset");
    measure(1, 512, rise, len, fat);
    chk("post_reset_rise",   32'(rise), 33);
    chk("post_reset_len",    32'(len),  86);
    chk("post_reset_period", 32'(fat),  512);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
